// File: rtl/lateral_pkg.sv
// Shared types and Q4.11 helpers for the lateral distance monitor.
package lateral_pkg;

  localparam int unsigned FRAC_BITS = 11;
  localparam logic [15:0] Q_ONE     = 16'h0800;
  localparam logic [15:0] Q_MAX     = 16'h7FFF;

  typedef enum logic [1:0] {
    MON_FILL,
    MON_SAFE,
    MON_WARN
  } mon_state_t;

  // Unsigned Q4.11 add clamped to the largest positive value.
  function automatic logic [15:0] sat_add_q(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, Q_MAX}) ? Q_MAX : s[15:0];
  endfunction

endpackage

// File: rtl/lateral_distance_monitor_window.sv
// Circular window of sample magnitudes with running sum and registered average.
module moving_average_window
  import lateral_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] mag,
  output logic [WIDTH-1:0] avg_out,
  output logic [WIDTH-1:0] avg_next,
  output logic             avg_stb,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned SW    = WIDTH + DEPTH_LOG2;

  logic [WIDTH-1:0]      win_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2:0]   fill_q;
  logic [SW-1:0]         sum_q;
  logic                  stb_q;
  logic [WIDTH-1:0]      avg_q;

  assign full     = (fill_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign avg_next = sum_q[SW-1:DEPTH_LOG2];
  assign avg_stb  = stb_q;
  assign avg_out  = avg_q;

  // Unfilled slots are zero, so the oldest entry needs no special case while filling.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
      stb_q    <= 1'b0;
      avg_q    <= '0;
    end else begin
      stb_q <= push;
      if (push) begin
        win_q[wr_ptr_q] <= mag;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        sum_q           <= sum_q + SW'(mag) - SW'(win_q[wr_ptr_q]);
        if (!full) fill_q <= fill_q + 1'b1;
      end
      if (stb_q) avg_q <= avg_next;
    end
  end

endmodule

// File: rtl/lateral_distance_monitor.sv
// Proximity monitor: edge-accepted samples, moving average, debounced warn FSM.
// Optional min_avg tracking enabled by defining LATERAL_MONITOR_MINHOLD_EN.
module lateral_distance_monitor
  import lateral_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned DEBOUNCE   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] dist_in,
  input  logic             dist_done,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] hysteresis,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             warn,
  output logic [7:0]       sample_count,
  output logic [WIDTH-1:0] min_avg
);

  localparam int unsigned      DW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MAX  = {1'b1, {(WIDTH-1){1'b0}}};

  logic             done_q, s1_v, accept;
  logic [WIDTH-1:0] dist_q, mag, avg_next, rel;
  logic             avg_stb, win_full, eval, avg_valid_q;
  logic [7:0]       cnt_q;
  mon_state_t       state_q, state_n;
  logic [DW-1:0]    deb_q, deb_n;

  assign accept = dist_done & ~done_q;
  assign eval   = avg_stb & win_full;
  assign rel    = sat_add_q(threshold, hysteresis);

  always_comb begin
    mag = dist_q;
    if (dist_q == NEG_MAX)  mag = POS_MAX;
    else if (dist_q[WIDTH-1]) mag = -dist_q;
  end

  moving_average_window #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .push     (s1_v),
    .mag      (mag),
    .avg_out  (avg_out),
    .avg_next (avg_next),
    .avg_stb  (avg_stb),
    .full     (win_full)
  );

  // done_q keeps tracking through clear so a held done is not re-accepted afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b0;
      s1_v        <= 1'b0;
      dist_q      <= '0;
      cnt_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      done_q <= dist_done;
      if (clear) begin
        s1_v        <= 1'b0;
        cnt_q       <= '0;
        avg_valid_q <= 1'b0;
      end else begin
        s1_v <= accept;
        if (accept) dist_q <= dist_in;
        if (s1_v && cnt_q != 8'hFF) cnt_q <= cnt_q + 1'b1;
        if (eval) avg_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= MON_FILL;
      deb_q   <= '0;
    end else begin
      state_q <= state_n;
      deb_q   <= deb_n;
    end
  end

  // FILL falls through to SAFE rules on the first valid average.
  always_comb begin
    state_n = state_q;
    deb_n   = deb_q;
    if (eval) begin
      unique case (state_q)
        MON_FILL, MON_SAFE: begin
          state_n = MON_SAFE;
          if (avg_next < threshold) begin
            if (deb_q == DEB_LAST) begin
              state_n = MON_WARN;
              deb_n   = '0;
            end else begin
              deb_n = deb_q + 1'b1;
            end
          end else begin
            deb_n = '0;
          end
        end
        MON_WARN: begin
          if (avg_next >= rel) begin
            if (deb_q == DEB_LAST) begin
              state_n = MON_SAFE;
              deb_n   = '0;
            end else begin
              deb_n = deb_q + 1'b1;
            end
          end else begin
            deb_n = '0;
          end
        end
        default: begin
          state_n = MON_FILL;
          deb_n   = '0;
        end
      endcase
    end
  end

  assign warn         = (state_q == MON_WARN);
  assign avg_valid    = avg_valid_q;
  assign sample_count = cnt_q;

`ifdef LATERAL_MONITOR_MINHOLD_EN
  logic [WIDTH-1:0] min_q;
  always_ff @(posedge clk) begin
    if (rst || clear) min_q <= POS_MAX;
    else if (eval && avg_next < min_q) min_q <= avg_next;
  end
  assign min_avg = min_q;
`else
  assign min_avg = POS_MAX;
`endif

endmodule

// File: tb/tb_lateral_distance_monitor.sv
// Scoreboard bench for lateral_distance_monitor with directed, hand-computed vectors.
module tb_lateral_distance_monitor;

  logic        clk = 1'b0;
  logic        rst, clear, dist_done;
  logic [15:0] dist_in, threshold, hysteresis;
  logic [15:0] avg_out, min_avg;
  logic        avg_valid, warn;
  logic [7:0]  sample_count;

  lateral_distance_monitor #(
    .WIDTH      (16),
    .DEPTH_LOG2 (2),
    .DEBOUNCE   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .dist_in      (dist_in),
    .dist_done    (dist_done),
    .threshold    (threshold),
    .hysteresis   (hysteresis),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .warn         (warn),
    .sample_count (sample_count),
    .min_avg      (min_avg)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    string       tag;
    logic [15:0] avg;
    logic        valid;
    logic        warn;
    logic [7:0]  cnt;
    logic [15:0] mn;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_cnt;
  logic [15:0] exp_min;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int unsigned due, input string tag, input logic [15:0] avg,
                          input logic v, input logic w);
    exp_t e;
    e.due = due; e.tag = tag; e.avg = avg; e.valid = v; e.warn = w; e.cnt = exp_cnt;
`ifdef LATERAL_MONITOR_MINHOLD_EN
    e.mn = exp_min;
`else
    e.mn = 16'h7FFF;
`endif
    sb.push_back(e);
  endtask

  // One done pulse; expected avg/valid/warn are due two cycles after the accept edge.
  task automatic pulse(input logic [15:0] d, input logic [15:0] avg, input logic v,
                       input logic w, input string tag);
    @(posedge clk); #1;
    dist_in = d; dist_done = 1'b1;
    @(posedge clk); #1;
    if (exp_cnt != 8'hFF) exp_cnt++;
    if (v && avg < exp_min) exp_min = avg;
    push_exp(cyc + 2, tag, avg, v, w);
    dist_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL %s: slot at cycle %0d not checked (now %0d)", sb[0].tag, sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() != 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, ".avg_out"},      {16'h0, avg_out},      {16'h0, mon_e.avg});
      chk({mon_e.tag, ".avg_valid"},    {31'h0, avg_valid},    {31'h0, mon_e.valid});
      chk({mon_e.tag, ".warn"},         {31'h0, warn},         {31'h0, mon_e.warn});
      chk({mon_e.tag, ".sample_count"}, {24'h0, sample_count}, {24'h0, mon_e.cnt});
      chk({mon_e.tag, ".min_avg"},      {16'h0, min_avg},      {16'h0, mon_e.mn});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; dist_done = 1'b0; dist_in = '0;
    threshold = 16'h1000; hysteresis = 16'h0400;
    exp_cnt = '0; exp_min = 16'h7FFF;
    repeat (3) @(posedge clk);
    #1;
    push_exp(cyc, "reset", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fill, then enter warn (three averages below 0x1000)
    pulse(16'h2000, 16'h0800, 1'b0, 1'b0, "fill1");
    pulse(16'h2000, 16'h1000, 1'b0, 1'b0, "fill2");
    pulse(16'h2000, 16'h1800, 1'b0, 1'b0, "fill3");
    pulse(16'h2000, 16'h2000, 1'b1, 1'b0, "fill4");
    pulse(16'h0400, 16'h1900, 1'b1, 1'b0, "enter5");
    pulse(16'h0400, 16'h1200, 1'b1, 1'b0, "enter6");
    pulse(16'h0400, 16'h0B00, 1'b1, 1'b0, "enter7");
    pulse(16'h0400, 16'h0400, 1'b1, 1'b0, "enter8");
    pulse(16'h0400, 16'h0400, 1'b1, 1'b1, "enter9");
    // Hysteresis: release level is 0x1400
    pulse(16'h1200, 16'h0780, 1'b1, 1'b1, "hold10");
    pulse(16'h1200, 16'h0B00, 1'b1, 1'b1, "hold11");
    pulse(16'h1200, 16'h0E80, 1'b1, 1'b1, "hold12");
    pulse(16'h1200, 16'h1200, 1'b1, 1'b1, "hold13");
    pulse(16'h1800, 16'h1380, 1'b1, 1'b1, "rel14");
    pulse(16'h1800, 16'h1500, 1'b1, 1'b1, "rel15");
    pulse(16'h1800, 16'h1680, 1'b1, 1'b1, "rel16");
    pulse(16'h1800, 16'h1800, 1'b1, 1'b0, "rel17");
    // Negative input and most-negative saturation
    pulse(16'hF400, 16'h1500, 1'b1, 1'b0, "neg18");
    pulse(16'hF400, 16'h1200, 1'b1, 1'b0, "neg19");
    pulse(16'hF400, 16'h0F00, 1'b1, 1'b0, "neg20");
    pulse(16'hF400, 16'h0C00, 1'b1, 1'b0, "neg21");
    pulse(16'h8000, 16'h28FF, 1'b1, 1'b0, "sat22");
    pulse(16'h8000, 16'h45FF, 1'b1, 1'b0, "sat23");
    pulse(16'h8000, 16'h62FF, 1'b1, 1'b0, "sat24");
    pulse(16'h8000, 16'h7FFF, 1'b1, 1'b0, "sat25");
    // Release level saturates to 0x7FFF; a full-scale average must release
    threshold = 16'h7F00; hysteresis = 16'h0400;
    pulse(16'h0000, 16'h5FFF, 1'b1, 1'b0, "rsat26");
    pulse(16'h0000, 16'h3FFF, 1'b1, 1'b0, "rsat27");
    pulse(16'h0000, 16'h1FFF, 1'b1, 1'b1, "rsat28");
    pulse(16'h8000, 16'h1FFF, 1'b1, 1'b1, "rsat29");
    pulse(16'h8000, 16'h3FFF, 1'b1, 1'b1, "rsat30");
    pulse(16'h8000, 16'h5FFF, 1'b1, 1'b1, "rsat31");
    pulse(16'h8000, 16'h7FFF, 1'b1, 1'b1, "rsat32");
    pulse(16'h8000, 16'h7FFF, 1'b1, 1'b1, "rsat33");
    pulse(16'h8000, 16'h7FFF, 1'b1, 1'b0, "rsat34");

    // Held done counts once
    @(posedge clk); #1;
    dist_in = 16'h0000; dist_done = 1'b1;
    @(posedge clk); #1;
    exp_cnt++;
    push_exp(cyc + 2, "held_first", 16'h5FFF, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    dist_done = 1'b0;
    push_exp(cyc + 2, "held_after", 16'h5FFF, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // clear on an accept edge discards the sample
    dist_in = 16'h2000; dist_done = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; dist_done = 1'b0;
    exp_cnt = '0; exp_min = 16'h7FFF;
    push_exp(cyc, "clear_now", 16'h0000, 1'b0, 1'b0);
    push_exp(cyc + 2, "clear_late", 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    pulse(16'h2000, 16'h0800, 1'b0, 1'b0, "after_clear");

    // rst one cycle after an accept edge
    @(posedge clk); #1;
    dist_in = 16'h1000; dist_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; dist_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0; exp_min = 16'h7FFF;
    push_exp(cyc, "rst_mid", 16'h0000, 1'b0, 1'b0);
    push_exp(cyc + 2, "rst_mid_late", 16'h0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Zero samples past 255: count saturates, averaging and warn continue
    for (int n = 1; n <= 258; n++)
      pulse(16'h0000, 16'h0000, (n >= 4), (n >= 6), $sformatf("cnt%0d", n));

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
